// File: rtl/note_voice_manager.sv
// Polyphonic voice allocator: tracks held PS/2 note keys across NUM_VOICES voices
// and produces registered per-voice left/right tone dividers with octave and harmony.
module note_voice_manager #(
    parameter int NUM_VOICES = 2,
    parameter int DIV_W      = 22,
    parameter int HARM_STEP  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [8:0]                  key_code,
    input  logic                        key_make,
    input  logic                        harmony_en,
    input  logic                        octave_up,
    input  logic                        octave_down,
    output logic [NUM_VOICES*DIV_W-1:0] note_div_left,
    output logic [NUM_VOICES*DIV_W-1:0] note_div_right,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [1:0]                  octave,
    output logic                        voice_stolen
);

    localparam logic [1:0] AGE_MAX = 2'(NUM_VOICES - 1);

    logic [NUM_VOICES-1:0] active_r, active_n;
    logic [8:0]            code_r [NUM_VOICES];
    logic [8:0]            code_n [NUM_VOICES];
    logic [2:0]            deg_r  [NUM_VOICES];
    logic [2:0]            deg_n  [NUM_VOICES];
    logic [1:0]            age_r  [NUM_VOICES];
    logic [1:0]            age_n  [NUM_VOICES];
    logic [1:0]            octave_r, octave_n;
    logic                  stolen_r;

    logic [3:0] key_info_s;
    logic       hit_s, free_s, steal_s;
    logic [1:0] hit_idx_s, free_idx_s, old_idx_s, old_age_s, chosen_s;

    // Returns {mapped, degree} for a scan code; extended codes never map.
    function automatic logic [3:0] key_lookup(input logic [8:0] code);
        case (code)
            9'h021:  key_lookup = {1'b1, 3'd0};
            9'h023:  key_lookup = {1'b1, 3'd1};
            9'h024:  key_lookup = {1'b1, 3'd2};
            9'h02B:  key_lookup = {1'b1, 3'd3};
            9'h034:  key_lookup = {1'b1, 3'd4};
            9'h01C:  key_lookup = {1'b1, 3'd5};
            9'h032:  key_lookup = {1'b1, 3'd6};
            default: key_lookup = {1'b0, 3'd0};
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] base_div(input logic [2:0] deg);
        case (deg)
            3'd0:    base_div = DIV_W'(32'd191570);
            3'd1:    base_div = DIV_W'(32'd170648);
            3'd2:    base_div = DIV_W'(32'd151515);
            3'd3:    base_div = DIV_W'(32'd143266);
            3'd4:    base_div = DIV_W'(32'd127551);
            3'd5:    base_div = DIV_W'(32'd113636);
            3'd6:    base_div = DIV_W'(32'd101215);
            default: base_div = DIV_W'(32'd0);
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] oct_shift(input logic [DIV_W-1:0] b,
                                                   input logic [1:0]       oct);
        case (oct)
            2'd0:    oct_shift = b << 1;
            2'd1:    oct_shift = b;
            2'd2:    oct_shift = b >> 1;
            default: oct_shift = b;
        endcase
    endfunction

    // Harmony wraps past degree 6 into the next octave up (one extra halving).
    function automatic logic [DIV_W-1:0] right_div(input logic [2:0] deg,
                                                   input logic [1:0] oct,
                                                   input logic       harm);
        logic [3:0] h;
        h = {1'b0, deg} + 4'(HARM_STEP);
        if (!harm) begin
            right_div = oct_shift(base_div(deg), oct);
        end else if (h <= 4'd6) begin
            right_div = oct_shift(base_div(h[2:0]), oct);
        end else begin
            right_div = oct_shift(base_div(3'(h - 4'd7)), oct) >> 1;
        end
    endfunction

    assign key_info_s = key_lookup(key_code);

    // Locate held code, lowest free voice and oldest voice (ties to lowest index).
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = 2'd0;
        free_s     = 1'b0;
        free_idx_s = 2'd0;
        old_idx_s  = 2'd0;
        old_age_s  = 2'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_r[v] && (code_r[v] == key_code) && !hit_s) begin
                hit_s     = 1'b1;
                hit_idx_s = 2'(v);
            end else begin
                hit_s = hit_s;
            end
            if (!active_r[v] && !free_s) begin
                free_s     = 1'b1;
                free_idx_s = 2'(v);
            end else begin
                free_s = free_s;
            end
            if (v == 0 || age_r[v] > old_age_s) begin
                old_idx_s = 2'(v);
                old_age_s = age_r[v];
            end else begin
                old_age_s = old_age_s;
            end
        end
    end

    // Next voice state for a press/release event.
    always_comb begin
        active_n = active_r;
        code_n   = code_r;
        deg_n    = deg_r;
        age_n    = age_r;
        steal_s  = 1'b0;
        chosen_s = free_s ? free_idx_s : old_idx_s;
        if (key_valid && key_info_s[3] && key_make && !hit_s) begin
            steal_s = !free_s;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (2'(v) == chosen_s) begin
                    active_n[v] = 1'b1;
                    code_n[v]   = key_code;
                    deg_n[v]    = key_info_s[2:0];
                    age_n[v]    = 2'd0;
                end else if (active_r[v] && age_r[v] < AGE_MAX) begin
                    age_n[v] = age_r[v] + 2'd1;
                end else begin
                    age_n[v] = age_r[v];
                end
            end
        end else if (key_valid && key_info_s[3] && !key_make && hit_s) begin
            active_n[hit_idx_s] = 1'b0;
            age_n[hit_idx_s]    = 2'd0;
        end else begin
            steal_s = 1'b0;
        end
    end

    // Octave step; simultaneous up and down cancel.
    always_comb begin
        octave_n = octave_r;
        if (octave_up && !octave_down && octave_r < 2'd2) begin
            octave_n = octave_r + 2'd1;
        end else if (octave_down && !octave_up && octave_r > 2'd0) begin
            octave_n = octave_r - 2'd1;
        end else begin
            octave_n = octave_r;
        end
    end

    // Voice state, octave and steal pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= '0;
            octave_r <= 2'd1;
            stolen_r <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                code_r[v] <= 9'd0;
                deg_r[v]  <= 3'd0;
                age_r[v]  <= 2'd0;
            end
        end else begin
            active_r <= active_n;
            octave_r <= octave_n;
            stolen_r <= steal_s;
            code_r   <= code_n;
            deg_r    <= deg_n;
            age_r    <= age_n;
        end
    end

    // Registered divider outputs from the already-updated voice state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_div_left  <= '0;
            note_div_right <= '0;
            voice_active   <= '0;
        end else begin
            voice_active <= active_r;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_r[v]) begin
                    note_div_left[v*DIV_W +: DIV_W]  <= oct_shift(base_div(deg_r[v]), octave_r);
                    note_div_right[v*DIV_W +: DIV_W] <= right_div(deg_r[v], octave_r, harmony_en);
                end else begin
                    note_div_left[v*DIV_W +: DIV_W]  <= DIV_W'(32'd0);
                    note_div_right[v*DIV_W +: DIV_W] <= DIV_W'(32'd0);
                end
            end
        end
    end

    assign octave       = octave_r;
    assign voice_stolen = stolen_r;

endmodule

// File: tb/tb_note_voice_manager.sv
// Directed self-checking bench for note_voice_manager (2 voices, 22-bit dividers).
module tb_note_voice_manager;

    localparam int NV = 2;
    localparam int DW = 22;

    logic           clk = 1'b0;
    logic           rst;
    logic           key_valid, key_make, harmony_en, octave_up, octave_down;
    logic [8:0]     key_code;
    logic [NV*DW-1:0] note_div_left, note_div_right;
    logic [NV-1:0]  voice_active;
    logic [1:0]     octave;
    logic           voice_stolen;

    int n_cmp = 0;
    int n_bad = 0;
    int stolen_cnt = 0;
    logic stolen_after, stolen_late;

    note_voice_manager #(.NUM_VOICES(NV), .DIV_W(DW), .HARM_STEP(2)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_make(key_make), .harmony_en(harmony_en), .octave_up(octave_up),
        .octave_down(octave_down), .note_div_left(note_div_left),
        .note_div_right(note_div_right), .voice_active(voice_active),
        .octave(octave), .voice_stolen(voice_stolen)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lft(input int v);
        return 32'(note_div_left[v*DW +: DW]);
    endfunction

    function automatic logic [31:0] rgt(input int v);
        return 32'(note_div_right[v*DW +: DW]);
    endfunction

    // Event at edge k; returns after edge k+1 so registered outputs are visible.
    task automatic key_ev(input logic [8:0] code, input logic make);
        @(negedge clk);
        key_valid = 1'b1; key_code = code; key_make = make;
        @(negedge clk);
        key_valid = 1'b0;
        stolen_after = voice_stolen;
        @(negedge clk);
        stolen_late = voice_stolen;
        stolen_cnt += int'(stolen_after) + int'(stolen_late);
    endtask

    task automatic oct_ev(input logic up, input logic down);
        @(negedge clk);
        octave_up = up; octave_down = down;
        @(negedge clk);
        octave_up = 1'b0; octave_down = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 9'd0; key_make = 1'b0;
        harmony_en = 1'b0; octave_up = 1'b0; octave_down = 1'b0;
        @(negedge clk);
        check_val("rst_active", 32'(voice_active), 32'd0);
        check_val("rst_left0", lft(0), 32'd0);
        check_val("rst_octave", 32'(octave), 32'd1);
        check_val("rst_stolen", 32'(voice_stolen), 32'd0);
        rst = 1'b0;

        // T1
        key_ev(9'h021, 1'b1);
        check_val("t1_left0", lft(0), 32'd191570);
        check_val("t1_right0", rgt(0), 32'd191570);
        check_val("t1_active", 32'(voice_active), 32'd1);
        key_ev(9'h021, 1'b0);
        check_val("t1_rel_left0", lft(0), 32'd0);
        check_val("t1_rel_active", 32'(voice_active), 32'd0);

        // T2 harmony, with wrap (deg6) and without (deg0)
        harmony_en = 1'b1;
        key_ev(9'h032, 1'b1);
        check_val("t2_left0", lft(0), 32'd101215);
        check_val("t2_right0", rgt(0), 32'd85324);
        key_ev(9'h021, 1'b1);
        check_val("t2_left1", lft(1), 32'd191570);
        check_val("t2_right1", rgt(1), 32'd151515);
        oct_ev(1'b1, 1'b0);
        check_val("t2_octave", 32'(octave), 32'd2);
        check_val("t2_up_left0", lft(0), 32'd50607);
        check_val("t2_up_right0", rgt(0), 32'd42662);
        check_val("t2_up_right1", rgt(1), 32'd75757);
        oct_ev(1'b0, 1'b1);
        harmony_en = 1'b0;
        @(negedge clk);
        check_val("t2_harm_off_right0", rgt(0), 32'd101215);
        key_ev(9'h032, 1'b0);
        key_ev(9'h021, 1'b0);
        check_val("t2_active", 32'(voice_active), 32'd0);

        // T3 steal oldest
        key_ev(9'h021, 1'b1);
        key_ev(9'h023, 1'b1);
        check_val("t3_pre_stolen", 32'(stolen_cnt), 32'd0);
        key_ev(9'h024, 1'b1);
        check_val("t3_left0", lft(0), 32'd151515);
        check_val("t3_left1", lft(1), 32'd170648);
        check_val("t3_stolen_pulse", 32'(stolen_after), 32'd1);
        check_val("t3_stolen_end", 32'(stolen_late), 32'd0);
        check_val("t3_active", 32'(voice_active), 32'd3);

        // T4 repeats, unmapped press, unheld release
        stolen_cnt = 0;
        for (int i = 0; i < 5; i++) key_ev(9'h024, 1'b1);
        key_ev(9'h015, 1'b1);
        key_ev(9'h034, 1'b0);
        check_val("t4_left0", lft(0), 32'd151515);
        check_val("t4_left1", lft(1), 32'd170648);
        check_val("t4_active", 32'(voice_active), 32'd3);
        check_val("t4_no_steal", 32'(stolen_cnt), 32'd0);
        // voice1 is now the oldest and must be the victim
        key_ev(9'h034, 1'b1);
        check_val("t4_steal_left1", lft(1), 32'd127551);
        check_val("t4_steal_left0", lft(0), 32'd151515);
        check_val("t4_steal_pulse", 32'(stolen_after), 32'd1);
        key_ev(9'h024, 1'b0);
        key_ev(9'h034, 1'b0);
        check_val("t4_active_end", 32'(voice_active), 32'd0);

        // T5 octave saturation
        key_ev(9'h021, 1'b1);
        for (int i = 0; i < 3; i++) oct_ev(1'b1, 1'b0);
        check_val("t5_oct_hi", 32'(octave), 32'd2);
        check_val("t5_left_hi", lft(0), 32'd95785);
        oct_ev(1'b1, 1'b1);
        check_val("t5_oct_both", 32'(octave), 32'd2);
        oct_ev(1'b0, 1'b1);
        check_val("t5_oct_mid", 32'(octave), 32'd1);
        for (int i = 0; i < 2; i++) oct_ev(1'b0, 1'b1);
        check_val("t5_oct_lo", 32'(octave), 32'd0);
        check_val("t5_left_lo", lft(0), 32'd383140);

        // T6 reset mid-operation
        key_ev(9'h023, 1'b1);
        check_val("t6_pre_active", 32'(voice_active), 32'd3);
        check_val("t6_pre_left1", lft(1), 32'd341296);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t6_rst_active", 32'(voice_active), 32'd0);
        check_val("t6_rst_left0", lft(0), 32'd0);
        check_val("t6_rst_right1", rgt(1), 32'd0);
        check_val("t6_rst_octave", 32'(octave), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        key_ev(9'h032, 1'b1);
        check_val("t6_left0", lft(0), 32'd101215);
        check_val("t6_active", 32'(voice_active), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
